cla_divider: RTL and testbench
==============================

# cla_divider

Sequential 8-bit by 4-bit unsigned restoring divider. It is the inverse of the team's combinational 4x4 multiplier: given an 8-bit product and a 4-bit factor, it recovers the other factor and a remainder. Every trial subtraction goes through a single ReversibleCLA8bit instance, computing R + ~D + 1, so the reversible-gate adder path stays the only arithmetic primitive. It has a valid/ready handshake on both input and output, so it can be placed after the multiplier or driven directly by a test harness.

## Interface
- Parameters: none. Widths are fixed: 8-bit dividend, 4-bit divisor, 8-bit quotient, 4-bit remainder.
- clk  input  1  Single clock; all state changes on the rising edge.
- rst_n  input  1  Reset, asynchronous assert, active-low.
- in_valid  input  1  The dividend/divisor pair is valid.
- in_ready  output  1  High exactly when state is IDLE.
- dividend  input  8  Unsigned dividend; sampled on acceptance.
- divisor  input  4  Unsigned divisor; sampled on acceptance.
- out_valid  output  1  Result is valid; high exactly when state is DONE.
- out_ready  input  1  Consumer accepts the result.
- quotient  output  8  Unsigned quotient.
- remainder  output  4  Unsigned remainder.
- div_by_zero  output  1  Set when the accepted divisor was 0.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: bit iteration, 3-bit counter cnt.
  - DONE: out_valid=1.
- IDLE, when in_valid=1:
  - Latch D={4'b0,divisor}, Q=dividend, R=8'h00, cnt=0.
  - If divisor==0, go to DONE: quotient=8'hFF, remainder=4'h0, div_by_zero=1.
  - Otherwise, go to RUN with div_by_zero=0.
- RUN, per cycle:
  - Form T={R[6:0],Q[7]}.
  - Compute T-D via the CLA: a=T, b=~D, cin=1.
  - If cout=1 (no borrow), R<=sum. Otherwise R<=T (restore).
  - Q<={Q[6:0],cout}.
  - cnt<=cnt+1. On cnt==7 the update completes and the state goes to DONE.
- DONE:
  - quotient=Q and remainder=R[3:0]. R[7:4] is always 0 by construction, and the bench must assert this.
  - Outputs hold stable while out_ready=0.
  - When out_ready=1, go to IDLE on the next edge.
- in_valid is ignored outside IDLE; no input is queued.
- Only one operation is in flight at a time.
- Reset (async, any state):
  - State goes to IDLE, and cnt, Q, R and D clear to 0.
  - Output values during reset: in_ready=1, out_valid=0, quotient=8'h00, remainder=4'h0, div_by_zero=0.
  - An in-flight result is discarded with no output.
  - in_valid is ignored while rst_n=0.
- Output registers (quotient, remainder, div_by_zero) keep their last values after leaving DONE. Consumers must qualify them with out_valid.

## Timing
- Acceptance: rising edge with in_valid=1 and in_ready=1 (call it edge 0).
- Normal latency: RUN covers edges 1..8. out_valid is first high after edge 8, i.e. 8 cycles after acceptance.
- Divide-by-zero latency: out_valid is high after edge 1.
- Result handshake: the result transfers on the edge with out_valid=1 and out_ready=1. in_ready is high from the following cycle.
- No same-cycle output-complete/input-accept overlap. Minimum initiation interval is 10 cycles (RUN ops, out_ready tied high) or 3 cycles (divide-by-zero).
- Combinational path per cycle is one 8-bit ripple through two 4-bit CLA stages plus the restore mux. Single-cycle closure is required.
- Input and output handshake signals are registered state decodes; there are no combinational input-to-output paths.

## Test plan
- 200/7: accept, then out_valid exactly 8 cycles later with quotient=28, remainder=4, div_by_zero=0.
- Boundaries:
  - 255/1 gives quotient=255, remainder=0.
  - 0/15 gives quotient=0, remainder=0.
  - 255/15 gives quotient=17, remainder=0.
  - 14/15 gives quotient=0, remainder=14.
- Divide by zero: dividend=0x5A, divisor=0. out_valid 1 cycle after accept with quotient=0xFF, remainder=0, div_by_zero=1. The next normal op (15/4 gives quotient=3, remainder=3) shows div_by_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - quotient, remainder and out_valid stay stable.
  - in_ready stays 0, and in_valid pulses in this window are ignored.
  - Then raise out_ready: in_ready=1 on the next cycle.
- Mid-operation reset: drop rst_n in cycle 4 of RUN.
  - Outputs go to reset values immediately (async): in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - After release, 195/13 gives quotient=15, remainder=0 with normal latency.
- Round-trip sweep: for all A,B in 1..15, feed dividend=A*B and divisor=B with random out_ready stalls. Every result must give quotient=A and remainder=0. Plus an exhaustive 256x16 comparison against / and % (quotient=0xFF, remainder=0 for divisor 0).

Source files
------------

// File: rtl/cla_divider.sv
// Sequential 8-bit by 4-bit unsigned restoring divider with valid/ready on both sides.
// Every trial subtraction R + ~D + 1 goes through one ReversibleCLA8bit instance.

module reversible_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
endmodule

module ReversibleCLA8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [2:0] carry;

  assign carry[0] = cin;

  // Two lookahead nibbles, rippled through the inter-stage carry.
  for (genvar gi = 0; gi < 2; gi++) begin : g_stage
    reversible_cla4 u_cla4 (
      .a    (a[gi*4 +: 4]),
      .b    (b[gi*4 +: 4]),
      .cin  (carry[gi]),
      .sum  (sum[gi*4 +: 4]),
      .cout (carry[gi+1])
    );
  end

  assign cout = carry[2];
endmodule

module cla_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg;
  logic [2:0] cnt_reg;
  logic [7:0] q_reg;
  logic [7:0] r_reg;
  logic [7:0] d_reg;
  logic [7:0] quotient_reg;
  logic [3:0] remainder_reg;
  logic       dbz_reg;
  logic       in_ready_reg;
  logic       out_valid_reg;

  logic [7:0] trial;
  logic [7:0] diff;
  logic       no_borrow;
  logic [7:0] r_next;
  logic [7:0] q_next;

  assign trial = {r_reg[6:0], q_reg[7]};

  ReversibleCLA8bit u_cla (
    .a    (trial),
    .b    (~d_reg),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  assign r_next = no_borrow ? diff : trial;
  assign q_next = {q_reg[6:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      q_reg         <= 8'h00;
      r_reg         <= 8'h00;
      d_reg         <= 8'h00;
      quotient_reg  <= 8'h00;
      remainder_reg <= 4'h0;
      dbz_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            d_reg        <= {4'b0000, divisor};
            q_reg        <= dividend;
            r_reg        <= 8'h00;
            cnt_reg      <= 3'd0;
            dbz_reg      <= (divisor == 4'h0);
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          // A zero divisor spends exactly one cycle here so its result lands one edge after accept.
          if (dbz_reg) begin
            quotient_reg  <= 8'hFF;
            remainder_reg <= 4'h0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            r_reg   <= r_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              quotient_reg  <= q_next;
              remainder_reg <= r_next[3:0];
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_cla_divider.sv
// Self-checking bench for cla_divider: directed table, backpressure, mid-run reset,
// round-trip sweep and exhaustive comparison against / and %.

module tb_cla_divider;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  cla_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         stall;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the all-ones quotient for divisor 0.
  function automatic void ref_div(input int a, input int b,
                                  output logic [7:0] q, output logic [3:0] r, output logic dbz);
    if (b == 0) begin
      q = 8'hFF; r = 4'h0; dbz = 1'b1;
    end else begin
      q = 8'(a / b); r = 4'(a % b); dbz = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] exp_q, input logic [3:0] exp_r, input logic exp_dbz,
                        input int stall, input bit pulse_in, input bit verbose);
    int wait_cnt;
    int lat;
    int exp_lat;
    logic [7:0] hold_q;
    logic [3:0] hold_r;
    logic       hold_dbz;
    exp_lat = (b == 4'h0) ? 1 : 8;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_drop", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (!out_valid) return;
    hold_q = quotient;
    hold_r = remainder;
    hold_dbz = div_by_zero;
    for (int s = 0; s < stall; s++) begin
      in_valid = pulse_in ? s[0] : 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_stable", {19'd0, quotient, remainder, div_by_zero}, {19'd0, hold_q, hold_r, hold_dbz});
    end
    in_valid = 1'b0;
    check("quotient", 32'(quotient), 32'(exp_q));
    check("remainder", 32'(remainder), 32'(exp_r));
    check("div_by_zero", 32'(div_by_zero), 32'(exp_dbz));
    check("r_upper_zero", 32'(dut.r_reg[7:4]), 32'd0);
    txn++;
    if (verbose)
      $display("txn %0d: %0d / %0d -> q=%0d r=%0d dbz=%0d", txn, a, b, quotient, remainder, div_by_zero);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_xfer_in_ready", 32'(in_ready), 32'd1);
    check("post_xfer_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] eq;
    logic [3:0] er;
    logic       ed;
    int         a_i;

    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 0};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 0};
    vecs[2] = '{8'd0,   4'd15, 8'd0,   4'd0,  1'b0, 0};
    vecs[3] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 0};
    vecs[4] = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0, 0};
    vecs[5] = '{8'h5A,  4'd0,  8'hFF,  4'd0,  1'b1, 0};
    vecs[6] = '{8'd15,  4'd4,  8'd3,   4'd3,  1'b0, 0};
    vecs[7] = '{8'd100, 4'd9,  8'd11,  4'd1,  1'b0, 5};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = 8'h00; divisor = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", {19'd0, quotient, remainder, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].stall, 1'b1, 1'b1);

    // Reset dropped in the fourth RUN cycle of 195/13.
    in_valid = 1'b1; dividend = 8'd195; divisor = 4'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b1; dividend = 8'd77; divisor = 4'd3;
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_outputs", {19'd0, quotient, remainder, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_idle", 32'(in_ready), 32'd1);
    check("after_reset_no_result", 32'(out_valid), 32'd0);
    run_op(8'd195, 4'd13, 8'd15, 4'd0, 1'b0, 0, 1'b0, 1'b1);

    // Round trip: product of A and B divided by B must give back A exactly.
    for (int b = 1; b <= 15; b++) begin
      for (int a = 1; a <= 15; a++) begin
        a_i = a * b;
        run_op(8'(a_i), 4'(b), 8'(a), 4'd0, 1'b0, int'($urandom_range(0, 3)), 1'b1, 1'b1);
      end
    end

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        ref_div(a, b, eq, er, ed);
        run_op(8'(a), 4'(b), eq, er, ed, 0, 1'b0, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
